// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, the TERC4 codebook,
// the alignment FSM states and the single-symbol decode function.
package tmds_pkg;

    // Control tokens as 10-bit symbols, bit 0 first on the wire.
    localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

    // HDMI TERC4 codebook; the array index is the decoded nibble.
    localparam logic [9:0] TERC4_CODE [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Alignment FSM states.
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } tmds_state_t;

    // Everything one symbol decodes to.
    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic       terc4_hit;
        logic [3:0] terc4;
    } tmds_dec_t;

    // Classify one symbol and decode it as control token, TERC4 and video
    // byte in parallel; the video byte is always produced, context decides
    // which interpretation is used.
    function automatic tmds_dec_t tmds_decode(input logic [9:0] sym);
        tmds_dec_t  r;
        logic [7:0] d;
        r = '0;
        d = sym[9] ? ~sym[7:0] : sym[7:0];
        r.data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r.data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        case (sym)
            CTRL_TOK_00: begin r.is_ctrl = 1'b1; r.ctrl = 2'b00; end
            CTRL_TOK_01: begin r.is_ctrl = 1'b1; r.ctrl = 2'b01; end
            CTRL_TOK_10: begin r.is_ctrl = 1'b1; r.ctrl = 2'b10; end
            CTRL_TOK_11: begin r.is_ctrl = 1'b1; r.ctrl = 2'b11; end
            default: ;
        endcase
        for (int j = 0; j < 16; j++) begin
            if (sym == TERC4_CODE[j]) begin
                r.terc4_hit = 1'b1;
                r.terc4     = 4'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_rx_channel_sym_decode.sv
// Combinational classify/decode of one TMDS symbol.
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       terc4_hit,
    output logic [3:0] terc4
);

    tmds_dec_t dec;

    // Decode the symbol and fan the struct out to named ports.
    always_comb begin
        dec       = tmds_decode(sym);
        is_ctrl   = dec.is_ctrl;
        ctrl      = dec.ctrl;
        data      = dec.data;
        terc4_hit = dec.terc4_hit;
        terc4     = dec.terc4;
    end

endmodule

// File: rtl/tmds_rx_channel.sv
// Single-channel TMDS receive decoder: finds word alignment by requesting
// bit-slips until a run of control tokens appears, then decodes symbols.
// Two-stage pipeline: sym_i -> sym_r (stage 1) -> decoded outputs (stage 2).
// The FSM works from the stage-1 classification, so locked and the decoded
// outputs change on the same edge.
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN   = 128,
    parameter int SEARCH_LEN = 2048,
    parameter int SLIP_WAIT  = 16,
    parameter int LOSS_LEN   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  sym_i,
    output logic        bitslip,
    output logic [3:0]  slip_cnt,
    output logic        locked,
    output logic        de,
    output logic [1:0]  ctrl,
    output logic [7:0]  data,
    output logic        terc4_hit,
    output logic [3:0]  terc4,
    output tmds_state_t fsm_state
);

    localparam int RUN_W    = $clog2(CTRL_RUN) + 1;
    localparam int SEARCH_W = $clog2(SEARCH_LEN) + 1;
    localparam int WAIT_W   = $clog2(SLIP_WAIT) + 1;
    localparam int LOSS_W   = $clog2(LOSS_LEN) + 1;

    logic [9:0]          sym_r;
    logic                dec_is_ctrl;
    logic [1:0]          dec_ctrl;
    logic [7:0]          dec_data;
    logic                dec_terc4_hit;
    logic [3:0]          dec_terc4;

    tmds_state_t         state, state_n;
    logic [RUN_W-1:0]    run_cnt, run_n, run_inc;
    logic [SEARCH_W-1:0] search_cnt, search_n, search_inc;
    logic [WAIT_W-1:0]   wait_cnt, wait_n, wait_inc;
    logic [LOSS_W-1:0]   loss_cnt, loss_n, loss_inc;
    logic [3:0]          slip_r, slip_n;

    tmds_sym_decode u_dec (
        .sym       (sym_r),
        .is_ctrl   (dec_is_ctrl),
        .ctrl      (dec_ctrl),
        .data      (dec_data),
        .terc4_hit (dec_terc4_hit),
        .terc4     (dec_terc4)
    );

    // Stage 1: register the incoming symbol.
    always_ff @(posedge clk) begin
        if (reset) sym_r <= '0;
        else       sym_r <= sym_i;
    end

    // Saturating increments; counters never wrap.
    always_comb begin
        run_inc    = (run_cnt == '1)    ? run_cnt    : run_cnt + RUN_W'(1);
        search_inc = (search_cnt == '1) ? search_cnt : search_cnt + SEARCH_W'(1);
        wait_inc   = (wait_cnt == '1)   ? wait_cnt   : wait_cnt + WAIT_W'(1);
        loss_inc   = (loss_cnt == '1)   ? loss_cnt   : loss_cnt + LOSS_W'(1);
    end

    // FSM state register together with its counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            search_cnt <= '0;
            wait_cnt   <= '0;
            loss_cnt   <= '0;
            slip_r     <= '0;
        end else begin
            state      <= state_n;
            run_cnt    <= run_n;
            search_cnt <= search_n;
            wait_cnt   <= wait_n;
            loss_cnt   <= loss_n;
            slip_r     <= slip_n;
        end
    end

    // Next state and counter updates; lock is tested before the slip limit
    // and a token is tested before the loss limit so both win their ties.
    always_comb begin
        state_n  = state;
        run_n    = run_cnt;
        search_n = search_cnt;
        wait_n   = wait_cnt;
        loss_n   = loss_cnt;
        slip_n   = slip_r;
        case (state)
            ST_SEARCH: begin
                run_n    = dec_is_ctrl ? run_inc : '0;
                search_n = search_inc;
                if (dec_is_ctrl && run_inc == RUN_W'(CTRL_RUN)) begin
                    state_n  = ST_LOCKED;
                    run_n    = '0;
                    search_n = '0;
                    loss_n   = '0;
                    slip_n   = '0;
                end else if (search_cnt == SEARCH_W'(SEARCH_LEN - 1)) begin
                    state_n  = ST_SLIP;
                    run_n    = '0;
                    search_n = '0;
                end
            end
            ST_SLIP: begin
                slip_n  = (slip_r == 4'd9) ? 4'd0 : slip_r + 4'd1;
                wait_n  = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                wait_n = wait_inc;
                if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_n  = ST_SEARCH;
                    run_n    = '0;
                    search_n = '0;
                    wait_n   = '0;
                end
            end
            ST_LOCKED: begin
                if (dec_is_ctrl) begin
                    loss_n = '0;
                end else if (loss_inc == LOSS_W'(LOSS_LEN)) begin
                    state_n  = ST_SEARCH;
                    run_n    = '0;
                    search_n = '0;
                    wait_n   = '0;
                    loss_n   = '0;
                    slip_n   = '0;
                end else begin
                    loss_n = loss_inc;
                end
            end
            default: state_n = ST_SEARCH;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        bitslip   = (state == ST_SLIP);
        locked    = (state == ST_LOCKED);
        slip_cnt  = slip_r;
        fsm_state = state;
    end

    // Stage 2: register decoded fields, forced to zero whenever the FSM is
    // not (about to be) locked so they track the locked output.
    always_ff @(posedge clk) begin
        if (reset || state_n != ST_LOCKED) begin
            de        <= 1'b0;
            ctrl      <= '0;
            data      <= '0;
            terc4_hit <= 1'b0;
            terc4     <= '0;
        end else begin
            de        <= ~dec_is_ctrl;
            ctrl      <= dec_ctrl;
            data      <= dec_data;
            terc4_hit <= dec_terc4_hit;
            terc4     <= dec_terc4;
        end
    end

endmodule
